// File: rtl/fiapp_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with an inverted tap, a registered
// observation port and a timed fault injector that corrupts one stage's next value.
module fiapp_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 8,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic             enable,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  input  logic             inj_req,
  input  logic [SEL_W-1:0] inj_stage,
  input  logic [1:0]       inj_mode,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic [WIDTH-1:0] inj_value,
  input  logic [CNT_W-1:0] inj_delay,
  input  logic [CNT_W-1:0] inj_len,
  input  logic             inj_clear,
  output logic             inj_ack,
  output logic             inj_err,
  output logic             inj_busy,
  output logic             inj_active,
  input  logic [SEL_W-1:0] obs_sel,
  output logic [WIDTH-1:0] obs_data
);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, PERM} state_t;

  localparam logic [SEL_W:0] DEPTH_V = (SEL_W+1)'(DEPTH);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [SEL_W-1:0] stage_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] value_q;
  logic             ack_q;
  logic             err_q;

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];
  logic [WIDTH-1:0] o3_q;
  logic [WIDTH-1:0] obs_q;
  logic [WIDTH-1:0] obs_d;
  logic             fault_on;
  logic             stage_ok;

  function automatic logic [WIDTH-1:0] corrupt(
    input logic [WIDTH-1:0] n,
    input logic [1:0]       mode,
    input logic [WIDTH-1:0] mask,
    input logic [WIDTH-1:0] value
  );
    case (mode)
      2'b00:   return n ^ mask;
      2'b01:   return n & ~mask;
      2'b10:   return n | mask;
      default: return (n & ~mask) | (value & mask);
    endcase
  endfunction

  assign stage_ok = {1'b0, inj_stage} < DEPTH_V;
  // A clear on the same edge makes that write nominal.
  assign fault_on = ((state_q == ACTIVE) || (state_q == PERM)) && !inj_clear;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] nom;
      if (gi == 0) begin : g_head
        assign nom = enable ? a : pipe_q[0];
      end else begin : g_body
        assign nom = pipe_q[gi-1];
      end
      assign pipe_d[gi] = (fault_on && (stage_q == SEL_W'(gi)))
                          ? corrupt(nom, mode_q, mask_q, value_q) : nom;
    end
  endgenerate

  always_comb begin
    obs_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (obs_sel == SEL_W'(i)) obs_d = pipe_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      o3_q  <= '0;
      obs_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
      o3_q  <= ~pipe_q[0];
      obs_q <= obs_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      stage_q <= '0;
      mode_q  <= '0;
      mask_q  <= '0;
      value_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (inj_req) begin
            if (!stage_ok) begin
              err_q <= 1'b1;
            end else begin
              ack_q   <= 1'b1;
              stage_q <= inj_stage;
              mode_q  <= inj_mode;
              mask_q  <= inj_mask;
              value_q <= inj_value;
              len_q   <= inj_len;
              if (inj_delay != '0) begin
                state_q <= ARMED;
                cnt_q   <= inj_delay;
              end else if (inj_len != '0) begin
                state_q <= ACTIVE;
                cnt_q   <= inj_len;
              end else begin
                state_q <= PERM;
                cnt_q   <= '0;
              end
            end
          end
        end
        ARMED: begin
          if (inj_clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(1)) begin
            if (len_q != '0) begin
              state_q <= ACTIVE;
              cnt_q   <= len_q;
            end else begin
              state_q <= PERM;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (inj_clear || (cnt_q == CNT_W'(1))) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          if (inj_clear) state_q <= IDLE;
        end
      endcase
    end
  end

  assign o1         = pipe_q[0];
  assign o2         = pipe_q[DEPTH-1];
  assign o3         = o3_q;
  assign obs_data   = obs_q;
  assign inj_ack    = ack_q;
  assign inj_err    = err_q;
  assign inj_busy   = (state_q != IDLE);
  assign inj_active = (state_q == ACTIVE) || (state_q == PERM);

endmodule

// File: doc/fiapp_pipe.md
Name: fiapp_pipe

Overview:
Parametrised successor to the single-bit fault-injection demo pipeline. It is a WIDTH-bit, DEPTH-stage register pipeline with a gated input stage and a registered inverted tap. It adds a hardware fault injector (bit-flip, stuck-at-0/1, force-value) with programmable delay and duration, plus a registered observation port for any stage. It is the RTL target for the DPI-driven signal-of-interest get/set flow; the C side drives the inj_* and obs_* ports.

Parameters:
WIDTH, 8, data width of every stage
DEPTH, 3, number of pipeline stages, must be at least 2
CNT_W, 8, width of the delay and duration counters
SEL_W, $clog2(DEPTH), width of the stage selects (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
a  in  WIDTH  pipeline input
enable  in  1  load enable for stage 0
o1  out  WIDTH  stage 0 (q[0])
o2  out  WIDTH  last stage (q[DEPTH-1])
o3  out  WIDTH  registered bitwise inverse of q[0]
inj_req  in  1  injection request, sampled only in IDLE
inj_stage  in  SEL_W  target stage
inj_mode  in  2  00 flip, 01 stuck-0, 10 stuck-1, 11 force
inj_mask  in  WIDTH  bits affected
inj_value  in  WIDTH  force data (mode 11 only)
inj_delay  in  CNT_W  edges to wait before the fault starts
inj_len  in  CNT_W  number of corrupted writes; 0 means permanent
inj_clear  in  1  abort or end the injection
inj_ack  out  1  one-cycle pulse: request accepted
inj_err  out  1  one-cycle pulse: inj_stage >= DEPTH
inj_busy  out  1  FSM not in IDLE
inj_active  out  1  FSM in ACTIVE or PERM
obs_sel  in  SEL_W  stage to observe
obs_data  out  WIDTH  registered q[obs_sel]

Behaviour:
- Reset (reset_n low, async): all stages, o3, obs_data = 0. FSM = IDLE. Counters = 0. inj_ack, inj_err, inj_busy, inj_active = 0. Asserting reset mid-injection aborts the injection; latched parameters are discarded.
- Nominal next values:
  - q[0] = enable ? a : q[0]
  - q[i] = q[i-1] for 1 <= i < DEPTH
  - o3 <= ~q[0]
- Nominal latency: a to o1 is 1 edge; a to o2 is DEPTH edges; a to o3 is 2 edges.
- Fault function applied to the target stage's next value N, on every edge while ACTIVE or PERM. This includes stage 0 while it is holding (enable=0).
  - flip: N ^ mask
  - stuck-0: N & ~mask
  - stuck-1: N | mask
  - force: (N & ~mask) | (value & mask)
- A corrupted value propagates downstream nominally. Non-target stages are never corrupted.
- FSM states: IDLE, ARMED, ACTIVE, PERM.
- IDLE:
  - inj_req with inj_stage >= DEPTH: inj_err pulses next cycle; FSM stays IDLE.
  - inj_req, valid stage: latch stage/mode/mask/value/len; inj_ack pulses next cycle.
  - Next state: ARMED with cnt = inj_delay if inj_delay > 0. Otherwise ACTIVE (len > 0, cnt = len) or PERM (len = 0).
- ARMED: cnt decrements each edge. At cnt = 1, move to ACTIVE/PERM as above.
- Timing: for an acceptance edge E0, the first corrupted write occurs at edge E0 + inj_delay + 1.
- ACTIVE: each edge performs one corrupted write and decrements cnt. The edge with cnt = 1 is the last corrupted write; FSM then returns to IDLE. Exactly inj_len corrupted writes occur.
- PERM: corrupts every edge until inj_clear.
- inj_clear in any non-IDLE state: the write on that edge is nominal; FSM goes to IDLE. inj_clear in IDLE has no effect.
- Simultaneous inj_clear and inj_req in IDLE: the request is accepted.
- inj_req while busy is ignored; no ack and no err.
- inj_ack and inj_err are never high together.
- Counters never wrap: a delay or length of 2^CNT_W-1 is legal.
- obs_data <= q[obs_sel] each edge (1-cycle latency). obs_sel >= DEPTH gives 0.

Test Plan:
1. Nominal pipeline (WIDTH=8, DEPTH=3): release reset, a=0xA5, enable=1 -> o1=0xA5 after 1 edge, o3=0x5A after 2, o2=0xA5 after 3; then enable=0, a=0x3C -> o1 holds 0xA5.
2. Transient flip: a=0x00 steady, inj_stage=1, mode=00, mask=0x01, delay=0, len=1 -> inj_ack pulse; q[1]=0x01 for exactly one cycle; o2=0x01 exactly one cycle later; inj_busy falls after that write.
3. Delayed stuck-1: stage 0, enable=0, q[0]=0x00, mask=0xF0, delay=3, len=2 -> o1=0xF0 starting at E0+4 for 2 writes; o1 then stays 0xF0 (held by enable=0, now nominal).
4. Permanent force plus clear: stage 2, mode=11, mask=0xFF, value=0x77, len=0, a=0x11 -> o2=0x77 every cycle; assert inj_clear -> o2=0x11 from the next write, inj_active=0.
5. Handshake edges: inj_req with inj_stage=3 -> inj_err pulse, no ack, FSM stays IDLE; second inj_req while busy -> no ack; obs_sel=1 -> obs_data equals q[1] one cycle later; obs_sel=3 -> 0.
6. Reset mid-injection: reset_n low during PERM -> all outputs 0 immediately; after release, a=0x01 propagates uncorrupted.
